mii_rx_frame_parser: RTL and testbench

- Downstream neighbour of the MII nibble-alignment stage; consumes its aligned 4-bit stream in the 25 MHz receive domain.
- Strips preamble/SFD and assembles nibbles into bytes.
- Emits a byte stream with sof/eof framing, frame length, CRC-32 status and error flags.
- Drives state_out, which the alignment stage uses to qualify its shift hunt (value 1 = preamble).

---
 rtl/mii_rx_frame_parser.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mii_rx_frame_parser.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_rx_frame_parser.sv
// mii_rx_frame_parser
// Receive-side MII frame parser. It sits downstream of the nibble-alignment
// stage and works on the aligned 4-bit stream in the 25 MHz receive domain.
// It strips the preamble and SFD, packs nibble pairs into bytes (low nibble
// first), and frames the byte stream with sof/eof. It also reports the frame
// length, the CRC-32 result and an error flag for each frame.
//
// Ports:
//   clk_25Mz       MII receive clock
//   reset_n        asynchronous active-low reset
//   data_sinhr_in  aligned nibble from the alignment stage
//   CRS, RX_DV     carrier sense / data valid, raw PHY timing (delayed here)
//   state_out      FSM state: 0 IDLE, 1 PREAMBLE, 2 DATA, 3 DROP
//   byte_out       assembled byte {high nibble, low nibble}
//   byte_valid     one-cycle pulse qualifying byte_out
//   sof            first data byte of a frame (coincides with byte_valid)
//   eof            one-cycle end-of-frame pulse
//   frame_len      byte count of the last frame, held from eof
//   crc_ok         CRC result of the last frame, held from eof
//   frame_err      error flag of the last frame, held from eof
module mii_rx_frame_parser #(
    parameter int DV_DELAY    = 2,
    parameter int MIN_PRE_NIB = 7,
    parameter int MAX_LEN     = 1522
) (
    input  logic        clk_25Mz,
    input  logic        reset_n,
    input  logic [3:0]  data_sinhr_in,
    input  logic        CRS,
    input  logic        RX_DV,
    output logic [2:0]  state_out,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        sof,
    output logic        eof,
    output logic [10:0] frame_len,
    output logic        crc_ok,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_DROP     = 3'd3
    } state_t;

    localparam logic [3:0]  MIN_PRE   = 4'(MIN_PRE_NIB);
    localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
    // Register value left by a correct frame (data + FCS) when the CRC is
    // shifted LSB first. In MSB-first bit order this is 0xC704DD7B.
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    // One byte of the reflected CRC-32, processed bit by bit, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_t               state_q, state_d;
    logic [DV_DELAY-1:0]  dv_sr_q, dv_sr_d;
    logic [DV_DELAY-1:0]  crs_sr_q, crs_sr_d;
    logic [3:0]           pre_cnt_q, pre_cnt_d;
    logic [10:0]          byte_cnt_q, byte_cnt_d;
    logic                 phase_q, phase_d;
    logic [3:0]           nib_lo_q, nib_lo_d;
    logic [31:0]          crc_q, crc_d;
    logic                 bad_pre_q, bad_pre_d;
    logic                 over_q, over_d;
    logic [7:0]           byte_out_q, byte_out_d;
    logic                 byte_valid_q, byte_valid_d;
    logic                 sof_q, sof_d;
    logic                 eof_q, eof_d;
    logic [10:0]          frame_len_q, frame_len_d;
    logic                 crc_ok_q, crc_ok_d;
    logic                 frame_err_q, frame_err_d;

    logic dv_d;
    logic crs_d;
    logic frame_end;
    logic fin_err;

    // RX_DV/CRS are delayed so that they line up with the alignment stage's
    // data latency.
    assign dv_d  = dv_sr_q[DV_DELAY-1];
    assign crs_d = crs_sr_q[DV_DELAY-1];

    // A frame ends when data valid drops in DATA or DROP. A frame that ends
    // in DATA with the high nibble still pending had an odd nibble count.
    assign frame_end = ((state_q == ST_DATA) || (state_q == ST_DROP)) && !dv_d;
    assign fin_err   = bad_pre_q | over_q | ((state_q == ST_DATA) & phase_q);

    // State register.
    always_ff @(posedge clk_25Mz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Only a drop of dv_d ends a frame; a drop of crs_d
    // alone is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dv_d && crs_d) begin
                    state_d = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (!dv_d) begin
                    state_d = ST_IDLE;
                end else if (data_sinhr_in == 4'h5) begin
                    state_d = ST_PREAMBLE;
                end else if ((data_sinhr_in == 4'hD) && (pre_cnt_q >= MIN_PRE)) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!dv_d) begin
                    state_d = ST_IDLE;
                end else if (phase_q && (byte_cnt_q >= MAX_LEN_L)) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!dv_d) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: delay lines, preamble and byte counters, nibble packing, CRC,
    // and the per-frame status that is captured on eof.
    always_comb begin
        dv_sr_d      = dv_sr_q << 1;
        dv_sr_d[0]   = RX_DV;
        crs_sr_d     = crs_sr_q << 1;
        crs_sr_d[0]  = CRS;
        pre_cnt_d    = pre_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        phase_d      = phase_q;
        nib_lo_d     = nib_lo_q;
        crc_d        = crc_q;
        bad_pre_d    = bad_pre_q;
        over_d       = over_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        frame_len_d  = frame_len_q;
        crc_ok_d     = crc_ok_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            ST_IDLE: begin
                if (dv_d && crs_d) begin
                    pre_cnt_d  = 4'd0;
                    byte_cnt_d = 11'd0;
                    phase_d    = 1'b0;
                    crc_d      = CRC_INIT;
                    bad_pre_d  = 1'b0;
                    over_d     = 1'b0;
                end
            end
            ST_PREAMBLE: begin
                if (dv_d) begin
                    if (data_sinhr_in == 4'h5) begin
                        if (pre_cnt_q != 4'hF) begin
                            pre_cnt_d = pre_cnt_q + 4'd1;
                        end
                    end else if ((data_sinhr_in == 4'hD) && (pre_cnt_q >= MIN_PRE)) begin
                        phase_d = 1'b0;
                    end else begin
                        bad_pre_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (dv_d) begin
                    if (!phase_q) begin
                        nib_lo_d = data_sinhr_in;
                        phase_d  = 1'b1;
                    end else if (byte_cnt_q >= MAX_LEN_L) begin
                        // This byte would exceed the maximum; swallow it.
                        over_d = 1'b1;
                    end else begin
                        byte_out_d   = {data_sinhr_in, nib_lo_q};
                        byte_valid_d = 1'b1;
                        sof_d        = (byte_cnt_q == 11'd0);
                        byte_cnt_d   = byte_cnt_q + 11'd1;
                        crc_d        = crc32_byte(crc_q, {data_sinhr_in, nib_lo_q});
                        phase_d      = 1'b0;
                    end
                end
            end
            default: begin
            end
        endcase

        if (frame_end) begin
            eof_d       = 1'b1;
            frame_len_d = (byte_cnt_q > MAX_LEN_L) ? MAX_LEN_L : byte_cnt_q;
            frame_err_d = fin_err;
            crc_ok_d    = (crc_q == CRC_RESIDUE) && !fin_err;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_25Mz or negedge reset_n) begin
        if (!reset_n) begin
            dv_sr_q      <= '0;
            crs_sr_q     <= '0;
            pre_cnt_q    <= 4'd0;
            byte_cnt_q   <= 11'd0;
            phase_q      <= 1'b0;
            nib_lo_q     <= 4'd0;
            crc_q        <= CRC_INIT;
            bad_pre_q    <= 1'b0;
            over_q       <= 1'b0;
            byte_out_q   <= 8'd0;
            byte_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            frame_len_q  <= 11'd0;
            crc_ok_q     <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            dv_sr_q      <= dv_sr_d;
            crs_sr_q     <= crs_sr_d;
            pre_cnt_q    <= pre_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            phase_q      <= phase_d;
            nib_lo_q     <= nib_lo_d;
            crc_q        <= crc_d;
            bad_pre_q    <= bad_pre_d;
            over_q       <= over_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            frame_len_q  <= frame_len_d;
            crc_ok_q     <= crc_ok_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Outputs.
    always_comb begin
        state_out  = state_q;
        byte_out   = byte_out_q;
        byte_valid = byte_valid_q;
        sof        = sof_q;
        eof        = eof_q;
        frame_len  = frame_len_q;
        crc_ok     = crc_ok_q;
        frame_err  = frame_err_q;
    end

endmodule

// File: tb/tb_mii_rx_frame_parser.sv
// Testbench for mii_rx_frame_parser. Directed frames are driven as nibbles.
// Expected bytes and end-of-frame status are queued when a frame is driven.
// A negedge monitor pops them as the parser emits bytes and eof pulses.
module tb_mii_rx_frame_parser;

    localparam int CLK_HALF = 20;

    typedef struct packed {
        logic [7:0] b;
        logic       s;
    } exp_byte_t;

    typedef struct packed {
        logic [10:0] len;
        logic        ok;
        logic        err;
    } exp_eof_t;

    logic        clk_25Mz = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  data_sinhr_in = 4'd0;
    logic        CRS = 1'b0;
    logic        RX_DV = 1'b0;
    logic [2:0]  state_out;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        sof;
    logic        eof;
    logic [10:0] frame_len;
    logic        crc_ok;
    logic        frame_err;

    int total = 0;
    int bad = 0;
    int eof_cnt = 0;
    int rx_bytes = 0;

    logic [3:0] pipe0 = 4'd0;
    logic [3:0] pipe1 = 4'd0;
    logic [7:0] frame_q[$];
    logic [3:0] pre_q[$];
    exp_byte_t  byte_q[$];
    exp_eof_t   eof_q[$];
    exp_byte_t  mon_b;
    exp_eof_t   mon_e;

    mii_rx_frame_parser dut (
        .clk_25Mz      (clk_25Mz),
        .reset_n       (reset_n),
        .data_sinhr_in (data_sinhr_in),
        .CRS           (CRS),
        .RX_DV         (RX_DV),
        .state_out     (state_out),
        .byte_out      (byte_out),
        .byte_valid    (byte_valid),
        .sof           (sof),
        .eof           (eof),
        .frame_len     (frame_len),
        .crc_ok        (crc_ok),
        .frame_err     (frame_err)
    );

    always #CLK_HALF clk_25Mz = ~clk_25Mz;

    // Single comparison point; every check in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Standard Ethernet FCS generator (reflected CRC-32).
    function automatic logic [31:0] crcModel(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // RX_DV/CRS are driven with PHY timing and the nibble two cycles later,
    // as the alignment stage would deliver it.
    task automatic driveNib(input logic dv, input logic [3:0] nib);
        @(negedge clk_25Mz);
        data_sinhr_in = pipe1;
        pipe1 = pipe0;
        pipe0 = nib;
        RX_DV = dv;
        CRS = dv;
    endtask

    task automatic buildPreamble(input int n_five, input int bad_at);
        pre_q.delete();
        for (int i = 0; i < n_five; i++) begin
            pre_q.push_back((i == bad_at) ? 4'h7 : 4'h5);
        end
        pre_q.push_back(4'hD);
    endtask

    task automatic buildFrame(input int n_payload, input bit with_fcs);
        logic [31:0] c;
        logic [31:0] fcs;
        logic [7:0]  b;
        frame_q.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n_payload; i++) begin
            b = 8'((i * 37 + 11) & 255);
            frame_q.push_back(b);
            c = crcModel(c, b);
        end
        if (with_fcs) begin
            fcs = ~c;
            frame_q.push_back(fcs[7:0]);
            frame_q.push_back(fcs[15:8]);
            frame_q.push_back(fcs[23:16]);
            frame_q.push_back(fcs[31:24]);
        end
    endtask

    // Drives pre_q + frame_q and checks the frame's outcome.
    task automatic applyStimulus(input string name, input bit extra_nib, input int exp_bytes,
                                 input logic [2:0] exp_state, input int exp_len,
                                 input bit exp_ok, input bit exp_err);
        exp_byte_t eb;
        exp_eof_t  ee;
        int e0;
        rx_bytes = 0;
        ee.len = 11'(exp_len);
        ee.ok = exp_ok;
        ee.err = exp_err;
        eof_q.push_back(ee);
        checkOutput({name, "_idle_state"}, 32'(state_out), 0);
        for (int i = 0; i < pre_q.size(); i++) begin
            driveNib(1'b1, pre_q[i]);
            if (i == 3) checkOutput({name, "_pre_state"}, 32'(state_out), 1);
        end
        for (int k = 0; k < frame_q.size(); k++) begin
            driveNib(1'b1, frame_q[k][3:0]);
            driveNib(1'b1, frame_q[k][7:4]);
            if (k < exp_bytes) begin
                eb.b = frame_q[k];
                eb.s = (k == 0);
                byte_q.push_back(eb);
            end
        end
        if (extra_nib) driveNib(1'b1, 4'hA);
        checkOutput({name, "_end_state"}, 32'(state_out), 32'(exp_state));
        e0 = eof_cnt;
        for (int c = 0; c < 30 && eof_cnt == e0; c++) driveNib(1'b0, 4'd0);
        checkOutput({name, "_eof_seen"}, 32'(eof_cnt - e0), 1);
        repeat (3) driveNib(1'b0, 4'd0);
        checkOutput({name, "_post_state"}, 32'(state_out), 0);
        checkOutput({name, "_byte_count"}, 32'(rx_bytes), 32'(exp_bytes));
        checkOutput({name, "_bytes_left"}, 32'(byte_q.size()), 0);
    endtask

    // Monitor: pops expectations as bytes and eof pulses appear.
    always @(negedge clk_25Mz) begin
        if (reset_n) begin
            if (eof) begin
                checkOutput("eof_byte_overlap", 32'(byte_valid), 0);
                checkOutput("eof_expected", 32'(eof_q.size() != 0), 1);
                if (eof_q.size() != 0) begin
                    mon_e = eof_q.pop_front();
                    checkOutput("frame_len", 32'(frame_len), 32'(mon_e.len));
                    checkOutput("crc_ok", 32'(crc_ok), 32'(mon_e.ok));
                    checkOutput("frame_err", 32'(frame_err), 32'(mon_e.err));
                end
                eof_cnt++;
            end
            if (byte_valid) begin
                rx_bytes++;
                checkOutput("byte_expected", 32'(byte_q.size() != 0), 1);
                if (byte_q.size() != 0) begin
                    mon_b = byte_q.pop_front();
                    checkOutput("byte_out", 32'(byte_out), 32'(mon_b.b));
                    checkOutput("sof", 32'(sof), 32'(mon_b.s));
                end
            end
        end
    end

    initial begin
        #(2 * CLK_HALF * 20000);
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_byte_t eb;
        int e0;

        // Reset state.
        #5 reset_n = 1'b0;
        repeat (2) driveNib(1'b0, 4'd0);
        checkOutput("rst_state", 32'(state_out), 0);
        checkOutput("rst_byte_out", 32'(byte_out), 0);
        checkOutput("rst_byte_valid", 32'(byte_valid), 0);
        checkOutput("rst_sof", 32'(sof), 0);
        checkOutput("rst_eof", 32'(eof), 0);
        checkOutput("rst_frame_len", 32'(frame_len), 0);
        checkOutput("rst_crc_ok", 32'(crc_ok), 0);
        checkOutput("rst_frame_err", 32'(frame_err), 0);
        reset_n = 1'b1;
        repeat (3) driveNib(1'b0, 4'd0);

        // Good 64-byte frame.
        buildPreamble(15, -1);
        buildFrame(60, 1'b1);
        applyStimulus("good", 1'b0, 64, 3'd2, 64, 1'b1, 1'b0);

        // One payload bit flipped after the FCS was computed.
        buildFrame(60, 1'b1);
        frame_q[10] = frame_q[10] ^ 8'h04;
        applyStimulus("bad_fcs", 1'b0, 64, 3'd2, 64, 1'b0, 1'b0);

        // Extra trailing nibble.
        buildFrame(60, 1'b1);
        applyStimulus("odd_nib", 1'b1, 64, 3'd2, 64, 1'b0, 1'b1);

        // Too few preamble nibbles before SFD.
        buildPreamble(4, -1);
        buildFrame(8, 1'b0);
        applyStimulus("short_pre", 1'b0, 0, 3'd3, 0, 1'b0, 1'b1);

        // Stray 0x7 inside the preamble.
        buildPreamble(15, 6);
        buildFrame(8, 1'b0);
        applyStimulus("bad_pre_nib", 1'b0, 0, 3'd3, 0, 1'b0, 1'b1);

        // 1530-byte frame: only 1522 bytes may come out.
        buildPreamble(15, -1);
        buildFrame(1530, 1'b0);
        applyStimulus("overlength", 1'b0, 1522, 3'd3, 1522, 1'b0, 1'b1);

        // Reset in the middle of a frame, at byte 20.
        buildFrame(60, 1'b1);
        e0 = eof_cnt;
        for (int i = 0; i < pre_q.size(); i++) driveNib(1'b1, pre_q[i]);
        for (int k = 0; k < 20; k++) begin
            driveNib(1'b1, frame_q[k][3:0]);
            driveNib(1'b1, frame_q[k][7:4]);
            eb.b = frame_q[k];
            eb.s = (k == 0);
            byte_q.push_back(eb);
        end
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_state", 32'(state_out), 0);
        checkOutput("midrst_byte_out", 32'(byte_out), 0);
        checkOutput("midrst_byte_valid", 32'(byte_valid), 0);
        checkOutput("midrst_sof", 32'(sof), 0);
        checkOutput("midrst_eof", 32'(eof), 0);
        checkOutput("midrst_frame_len", 32'(frame_len), 0);
        checkOutput("midrst_crc_ok", 32'(crc_ok), 0);
        checkOutput("midrst_frame_err", 32'(frame_err), 0);
        byte_q.delete();
        repeat (3) driveNib(1'b0, 4'd0);
        reset_n = 1'b1;
        repeat (5) driveNib(1'b0, 4'd0);
        checkOutput("midrst_no_eof", 32'(eof_cnt - e0), 0);

        // A good frame parses correctly after the reset.
        applyStimulus("after_rst", 1'b0, 64, 3'd2, 64, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
